tt_scan_ctrl: RTL



---
 rtl/tt_scan_pkg.sv | 23 ++
 rtl/tt_scan_shreg.sv | 54 +++++
 rtl/tt_scan_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the tt_dpll scan-chain master.
// The CAPT/UNLOAD states exist only when TT_SCAN_CAPTURE_EN is defined.
package tt_scan_pkg;

    localparam int TT_SCAN_CHAIN_LEN_DEFAULT = 64;

`ifdef TT_SCAN_CAPTURE_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_CAPT   = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_DONE   = 3'd4
    } tt_scan_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_DONE   = 3'd4
    } tt_scan_state_e;
`endif

endpackage

// File: rtl/tt_scan_shreg.sv
// Parallel-load shift register feeding the chain, plus the capture register
// collecting bits returned from the end of the chain.
module tt_scan_shreg
    import tt_scan_pkg::*;
#(
    parameter int CHAIN_LEN = TT_SCAN_CHAIN_LEN_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic                 i_clr_cap,
    input  logic                 i_shift,
    input  logic [CHAIN_LEN-1:0] i_load_data,
    input  logic                 i_scan_in,
    output logic                 o_scan_bit,
    output logic [CHAIN_LEN-2:0] o_creg
);

    localparam int CW = CHAIN_LEN - 1;

    logic [CHAIN_LEN-1:0] sreg_q, sreg_d;
    // Only the first CHAIN_LEN-1 samples are stored; the last sample of a
    // burst goes straight into the output word together with these.
    logic [CW-1:0]        creg_q, creg_d;

    always_comb begin
        sreg_d = sreg_q;
        creg_d = creg_q;
        if (i_load) begin
            sreg_d = i_load_data;
        end else if (i_shift) begin
            sreg_d = {1'b0, sreg_q[CHAIN_LEN-1:1]};
        end
        if (i_clr_cap) begin
            creg_d = '0;
        end else if (i_shift) begin
            creg_d = CW'({i_scan_in, creg_q} >> 1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sreg_q <= '0;
            creg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
            creg_q <= creg_d;
        end
    end

    assign o_scan_bit = sreg_q[0];
    assign o_creg     = creg_q;

endmodule

// File: rtl/tt_scan_ctrl.sv
// Scan-chain master for tt_dpll: loads a CHAIN_LEN-bit vector and returns the
// previous chain contents. Optional functional capture cycle: TT_SCAN_CAPTURE_EN.
module tt_scan_ctrl
    import tt_scan_pkg::*;
#(
    parameter int CHAIN_LEN = TT_SCAN_CHAIN_LEN_DEFAULT
) (
    input  logic                 i_clk_gen,
    input  logic                 i_rst_n,
    input  logic                 i_start,
`ifdef TT_SCAN_CAPTURE_EN
    input  logic                 i_capture,
`endif
    input  logic [CHAIN_LEN-1:0] i_wdata,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CHAIN_LEN-1:0] o_rdata,
    output logic                 o_scan_en,
    output logic                 o_scan_out,
    input  logic                 i_scan_in,
    output logic [2:0]           o_dbg_state
);

    localparam int               CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    // Handshake: i_start is a request taken only in IDLE (otherwise dropped,
    // never queued); o_done pulses one cycle and o_rdata then holds until the
    // next o_done.
    tt_scan_state_e       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 scan_en_q, scan_en_d;
    logic [CHAIN_LEN-1:0] rdata_q, rdata_d;

    logic                 sh_load;
    logic                 sh_clr;
    logic                 sh_shift;
    logic [CHAIN_LEN-1:0] sh_data;
    logic [CHAIN_LEN-2:0] creg;
    logic                 go_capt;

`ifdef TT_SCAN_CAPTURE_EN
    logic                 cap_q, cap_d;
    logic [CHAIN_LEN-1:0] wcopy_q, wcopy_d;

    // Only the first burst of a capture operation leads into CAPT.
    assign go_capt = (state_q == ST_SHIFT) && cap_q;
`else
    assign go_capt = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        scan_en_d = 1'b0;
        rdata_d   = rdata_q;
        sh_load   = 1'b0;
        sh_clr    = 1'b0;
        sh_shift  = 1'b0;
        sh_data   = i_wdata;
`ifdef TT_SCAN_CAPTURE_EN
        cap_d     = cap_q;
        wcopy_d   = wcopy_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    sh_load   = 1'b1;
                    sh_clr    = 1'b1;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    scan_en_d = 1'b1;
                    state_d   = ST_SHIFT;
`ifdef TT_SCAN_CAPTURE_EN
                    cap_d     = i_capture;
                    wcopy_d   = i_wdata;
`endif
                end
            end
`ifdef TT_SCAN_CAPTURE_EN
            ST_SHIFT, ST_UNLOAD: begin
`else
            ST_SHIFT: begin
`endif
                sh_shift = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q != CNT_LAST) begin
                    busy_d    = 1'b1;
                    scan_en_d = 1'b1;
                end else if (go_capt) begin
                    busy_d  = 1'b1;
`ifdef TT_SCAN_CAPTURE_EN
                    state_d = ST_CAPT;
`endif
                end else begin
                    done_d  = 1'b1;
                    rdata_d = {i_scan_in, creg};
                    state_d = ST_DONE;
                end
            end
`ifdef TT_SCAN_CAPTURE_EN
            ST_CAPT: begin
                // Scan enable is low for this edge, so the chain captures its
                // functional state while sreg is rearmed with the same vector.
                sh_load   = 1'b1;
                sh_data   = wcopy_q;
                cnt_d     = '0;
                busy_d    = 1'b1;
                scan_en_d = 1'b1;
                state_d   = ST_UNLOAD;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scan_en_q <= 1'b0;
            rdata_q   <= '0;
`ifdef TT_SCAN_CAPTURE_EN
            cap_q     <= 1'b0;
            wcopy_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scan_en_q <= scan_en_d;
            rdata_q   <= rdata_d;
`ifdef TT_SCAN_CAPTURE_EN
            cap_q     <= cap_d;
            wcopy_q   <= wcopy_d;
`endif
        end
    end

    tt_scan_shreg #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_shreg (
        .i_clk       (i_clk_gen),
        .i_rst_n     (i_rst_n),
        .i_load      (sh_load),
        .i_clr_cap   (sh_clr),
        .i_shift     (sh_shift),
        .i_load_data (sh_data),
        .i_scan_in   (i_scan_in),
        .o_scan_bit  (o_scan_out),
        .o_creg      (creg)
    );

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_scan_en   = scan_en_q;
    assign o_rdata     = rdata_q;
    assign o_dbg_state = state_q;

endmodule
